// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

endpackage : ram_arb_pkg

// File: rtl/ram_arb_rr.sv
// Two-input grant picker: lock hold, then round robin (or fixed A priority
// when RAM_ARB_FIXED_PRIO_EN is defined), then single requester.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    input  logic       cur,
    output logic       gnt,
    output logic       gnt_vld
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // A lock only holds the grant while its owner keeps requesting.
    always_comb begin
        gnt     = PORT_A;
        gnt_vld = 1'b0;
        if (lock && req[cur]) begin
            gnt     = cur;
            gnt_vld = 1'b1;
        end else if (req[PORT_A] && req[PORT_B]) begin
            gnt_vld = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt     = PORT_A;
`else
            gnt     = ~last;
`endif
        end else if (req[PORT_A]) begin
            gnt     = PORT_A;
            gnt_vld = 1'b1;
        end else if (req[PORT_B]) begin
            gnt     = PORT_B;
            gnt_vld = 1'b1;
        end
    end

endmodule : ram_arb_rr

// File: rtl/ram_arb2.sv
// Two-master arbiter in front of the negedge-clocked byte-enable RAM.
// Define RAM_ARB_FIXED_PRIO_EN (in ram_arb_rr) for fixed port-A priority.
module ram_arb2
    import ram_arb_pkg::*;
#(
    parameter  int unsigned NUM_KBYTES = 128,
    localparam int unsigned ADDR_W     = $clog2(NUM_KBYTES * 1024)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_wr,
    input  logic              a_be,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_wr,
    input  logic              b_be,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e state_q, state_d;
    logic   rr_last_q, rr_last_d;

    logic [1:0] pick_req;
    logic       pick_lock;
    logic       pick_cur;
    logic       gnt;
    logic       gnt_vld;

    assign pick_req  = {b_req, a_req};
    assign pick_cur  = (state_q == SERVE_B) ? PORT_B : PORT_A;
    assign pick_lock = ((state_q == SERVE_A) && a_lock) ||
                       ((state_q == SERVE_B) && b_lock);

    ram_arb_rr u_rr (
        .req     (pick_req),
        .last    (rr_last_q),
        .lock    (pick_lock),
        .cur     (pick_cur),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // rr_last tracks the port being served, so it reads x throughout SERVE_x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= PORT_B;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Next state plus datapath mux; RAM pins follow the served port directly.
    always_comb begin
        state_d   = IDLE;
        rr_last_d = rr_last_q;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        a_rdata   = '0;
        b_rdata   = '0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        if (gnt_vld) begin
            state_d   = (gnt == PORT_A) ? SERVE_A : SERVE_B;
            rr_last_d = gnt;
        end

        case (state_q)
            SERVE_A: begin
                ram_en    = 1'b1;
                ram_we    = a_wr;
                ram_be    = a_be;
                ram_addr  = a_addr;
                ram_wdata = a_wdata;
                a_ack     = 1'b1;
                a_rdata   = ram_rdata;
            end
            SERVE_B: begin
                ram_en    = 1'b1;
                ram_we    = b_wr;
                ram_be    = b_be;
                ram_addr  = b_addr;
                ram_wdata = b_wdata;
                b_ack     = 1'b1;
                b_rdata   = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule : ram_arb2
